core_imem_resp: RTL and testbench

Instruction-memory responder serving the fetch stage. Accepts fetch requests (byte address) on a valid/ready channel, reads a word-addressed instruction RAM, and returns instruction words in order on a valid/ready response channel after a fixed pipeline latency. Supports a pipeline flush on taken branches and a side-band preload port used by the testbench and boot loader.

---
 rtl/core_imem_resp.sv | 141 ++++++++++++++
 tb/tb_core_imem_resp.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_imem_resp.sv
// Instruction-memory responder: in-order fetch responses after a fixed latency,
// with flush on taken branches and a side-band preload write port.
module core_imem_resp #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] BASE_ADDR       = 32'h4000_0000,
    parameter int              DEPTH_WORDS     = 1024,
    parameter int              LATENCY         = 2,
    parameter int              MAX_OUTSTANDING = 4,
    localparam int             IDXW            = $clog2(DEPTH_WORDS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic            i_flush,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [31:0]     o_resp_instr,
    output logic [XLEN-1:0] o_resp_addr,
    output logic            o_resp_fault,
    input  logic            i_load_en,
    input  logic [IDXW-1:0] i_load_addr,
    input  logic [31:0]     i_load_data
);

    localparam int QW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int LAST = LATENCY - 1;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [XLEN-1:0] req_off;
    logic [IDXW-1:0] req_idx;
    logic            req_fault;
    logic            accept;

    logic [LATENCY-1:0] p_valid;
    logic [XLEN-1:0]    p_addr  [LATENCY];
    logic               p_fault [LATENCY];
    logic [31:0]        p_data  [LATENCY];

    logic [XLEN-1:0]    q_addr  [MAX_OUTSTANDING];
    logic               q_fault [MAX_OUTSTANDING];
    logic [31:0]        q_data  [MAX_OUTSTANDING];
    logic [QW-1:0]      q_head;
    logic [QW-1:0]      q_tail;
    logic [CW-1:0]      q_cnt;
    logic [CW-1:0]      out_cnt;

    logic               q_empty;
    logic               resp_hs;
    logic               q_push;
    logic               q_pop;
    logic [XLEN-1:0]    sel_addr;
    logic               sel_fault;
    logic [31:0]        sel_data;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Addresses below BASE_ADDR wrap to a huge offset and land in the range fault.
    assign req_off   = i_req_addr - BASE_ADDR;
    assign req_idx   = req_off[IDXW+1:2];
    assign req_fault = (i_req_addr[1:0] != 2'b00) || ((req_off >> 2) >= XLEN'(DEPTH_WORDS));

    assign o_req_ready = !i_rst && !i_flush && (out_cnt < CW'(MAX_OUTSTANDING));
    assign accept      = i_req_valid && o_req_ready;

    assign q_empty      = (q_cnt == '0);
    assign o_resp_valid = !q_empty || p_valid[LAST];
    assign resp_hs      = o_resp_valid && i_resp_ready;
    assign q_pop        = resp_hs && !q_empty;
    // The last pipeline stage bypasses the queue only when it is consumed immediately.
    assign q_push       = p_valid[LAST] && !(q_empty && resp_hs);

    always_comb begin
        sel_addr  = '0;
        sel_fault = 1'b0;
        sel_data  = '0;
        if (!q_empty) begin
            sel_addr  = q_addr[q_head];
            sel_fault = q_fault[q_head];
            sel_data  = q_data[q_head];
        end else if (p_valid[LAST]) begin
            sel_addr  = p_addr[LAST];
            sel_fault = p_fault[LAST];
            sel_data  = p_data[LAST];
        end
    end

    assign o_resp_addr  = sel_addr;
    assign o_resp_fault = sel_fault;
    assign o_resp_instr = sel_fault ? 32'h0 : sel_data;

    always_ff @(posedge i_clk) begin
        if (i_load_en) begin
            mem[i_load_addr] <= i_load_data;
        end
        if (accept) begin
            p_data[0]  <= mem[req_idx];
            p_addr[0]  <= i_req_addr;
            p_fault[0] <= req_fault;
        end
        for (int i = 1; i < LATENCY; i++) begin
            p_data[i]  <= p_data[i-1];
            p_addr[i]  <= p_addr[i-1];
            p_fault[i] <= p_fault[i-1];
        end
        if (q_push) begin
            q_data[q_tail]  <= p_data[LAST];
            q_addr[q_tail]  <= p_addr[LAST];
            q_fault[q_tail] <= p_fault[LAST];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            p_valid <= '0;
            q_head  <= '0;
            q_tail  <= '0;
            q_cnt   <= '0;
            out_cnt <= '0;
        end else begin
            p_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
            end
            if (q_push) begin
                q_tail <= ptr_inc(q_tail);
            end
            if (q_pop) begin
                q_head <= ptr_inc(q_head);
            end
            q_cnt   <= q_cnt + CW'(q_push) - CW'(q_pop);
            out_cnt <= out_cnt + CW'(accept) - CW'(resp_hs);
        end
    end

endmodule

// File: tb/tb_core_imem_resp.sv
// Directed bench for core_imem_resp: table of single fetches plus hand-written
// sequences for backpressure, flush, same-cycle preload and mid-flight reset.
module tb_core_imem_resp;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_flush;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_resp_instr;
    logic [31:0] o_resp_addr;
    logic        o_resp_fault;
    logic        i_load_en;
    logic [9:0]  i_load_addr;
    logic [31:0] i_load_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] words [4];

    core_imem_resp dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_flush      (i_flush),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_instr (o_resp_instr),
        .o_resp_addr  (o_resp_addr),
        .o_resp_fault (o_resp_fault),
        .i_load_en    (i_load_en),
        .i_load_addr  (i_load_addr),
        .i_load_data  (i_load_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
        i_load_en   = 1'b1;
        i_load_addr = idx;
        i_load_data = data;
        tick();
        i_load_en   = 1'b0;
    endtask

    // One request with i_resp_ready high; the response must arrive two cycles after accept.
    task automatic req_check(input string nm, input logic [31:0] addr,
                             input logic [31:0] exp_instr, input logic exp_fault,
                             input logic ld_en, input logic [9:0] ld_idx,
                             input logic [31:0] ld_data);
        int lat;
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_load_en   = ld_en;
        i_load_addr = ld_idx;
        i_load_data = ld_data;
        #1;
        chk({nm, "_ready"}, o_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
        i_load_en   = 1'b0;
        #1;
        lat = 1;
        while (!o_resp_valid && lat < 8) begin
            tick();
            #1;
            lat++;
        end
        chk({nm, "_lat"}, lat, 2);
        chk({nm, "_instr"}, o_resp_instr, exp_instr);
        chk({nm, "_addr"}, o_resp_addr, addr);
        chk({nm, "_fault"}, o_resp_fault, exp_fault);
        tick();
        #1;
        chk({nm, "_idle"}, o_resp_valid, 0);
    endtask

    initial begin
        int acc;

        words[0] = 32'h0000_0093;
        words[1] = 32'h0010_0113;
        words[2] = 32'h0020_0193;
        words[3] = 32'h0030_0213;

        vecs[0] = '{"misalign2", 32'h4000_0002, 32'h0, 1'b1};
        vecs[1] = '{"past_end",  32'h4000_1000, 32'h0, 1'b1};
        vecs[2] = '{"below",     32'h3FFF_FFFC, 32'h0, 1'b1};
        vecs[3] = '{"word2",     32'h4000_0008, 32'h0020_0193, 1'b0};
        vecs[4] = '{"last_word", 32'h4000_0FFC, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{"misalign3", 32'h4000_0003, 32'h0, 1'b1};

        i_rst        = 1'b1;
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        i_flush      = 1'b0;
        i_resp_ready = 1'b0;
        i_load_en    = 1'b0;
        i_load_addr  = '0;
        i_load_data  = '0;

        tick();
        for (int k = 0; k < 4; k++) load_word(10'(k), words[k]);
        load_word(10'd5, 32'h1111_1111);
        load_word(10'd1023, 32'hCAFE_F00D);

        #1;
        chk("rst_ready", o_req_ready, 0);
        chk("rst_valid", o_resp_valid, 0);
        chk("rst_instr", o_resp_instr, 0);
        chk("rst_addr", o_resp_addr, 0);
        chk("rst_fault", o_resp_fault, 0);

        // Two back-to-back fetches
        i_rst        = 1'b0;
        i_resp_ready = 1'b1;
        #1;
        chk("rel_ready", o_req_ready, 1);
        i_req_valid = 1'b1;
        i_req_addr  = BASE;
        #1;
        chk("b2b_ready0", o_req_ready, 1);
        tick();
        i_req_addr = BASE + 32'd4;
        #1;
        chk("b2b_ready1", o_req_ready, 1);
        chk("b2b_early", o_resp_valid, 0);
        tick();
        i_req_valid = 1'b0;
        #1;
        chk("b2b_v0", o_resp_valid, 1);
        chk("b2b_i0", o_resp_instr, 32'h0000_0093);
        chk("b2b_a0", o_resp_addr, BASE);
        chk("b2b_f0", o_resp_fault, 0);
        tick();
        #1;
        chk("b2b_v1", o_resp_valid, 1);
        chk("b2b_i1", o_resp_instr, 32'h0010_0113);
        chk("b2b_a1", o_resp_addr, BASE + 32'd4);
        chk("b2b_f1", o_resp_fault, 0);
        tick();
        #1;
        chk("b2b_done", o_resp_valid, 0);

        // Backpressure: only MAX_OUTSTANDING accepted, in-order drain
        i_resp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            i_req_valid = 1'b1;
            i_req_addr  = BASE + 32'(4 * acc);
            #1;
            if (o_req_ready) acc++;
            tick();
        end
        i_req_valid = 1'b0;
        #1;
        chk("bp_accepted", 32'(acc), 4);
        chk("bp_ready_low", o_req_ready, 0);
        chk("bp_valid", o_resp_valid, 1);
        chk("bp_hold_a", o_resp_addr, BASE);
        tick();
        #1;
        chk("bp_stable_a", o_resp_addr, BASE);
        chk("bp_stable_i", o_resp_instr, words[0]);
        i_resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_v%0d", k), o_resp_valid, 1);
            chk($sformatf("bp_a%0d", k), o_resp_addr, BASE + 32'(4 * k));
            chk($sformatf("bp_i%0d", k), o_resp_instr, words[k]);
            tick();
            #1;
            if (k == 0) chk("bp_ready_back", o_req_ready, 1);
        end
        chk("bp_drained", o_resp_valid, 0);

        for (int v = 0; v < 6; v++) begin
            req_check(vecs[v].name, vecs[v].addr, vecs[v].exp_instr, vecs[v].exp_fault,
                      1'b0, 10'd0, 32'h0);
        end

        // Flush one cycle before the first response would show
        i_req_valid = 1'b1;
        i_req_addr  = BASE;
        #1;
        chk("fl1_ready", o_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
        i_flush     = 1'b1;
        #1;
        chk("fl1_ready_low", o_req_ready, 0);
        tick();
        i_flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("fl1_none%0d", k), o_resp_valid, 0);
            tick();
        end

        // Flush with three in flight, then an immediate fresh request
        i_resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_req_valid = 1'b1;
            i_req_addr  = BASE + 32'(4 * k);
            #1;
            chk($sformatf("fl3_acc%0d", k), o_req_ready, 1);
            tick();
        end
        i_req_valid = 1'b0;
        i_flush     = 1'b1;
        #1;
        chk("fl3_ready_low", o_req_ready, 0);
        tick();
        i_flush      = 1'b0;
        i_resp_ready = 1'b1;
        #1;
        chk("fl3_cleared", o_resp_valid, 0);
        req_check("post_flush", BASE + 32'h8, words[2], 1'b0, 1'b0, 10'd0, 32'h0);

        // Same-cycle preload returns old data; next fetch sees the new word
        req_check("ld_old", BASE + 32'h14, 32'h1111_1111, 1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF);
        req_check("ld_new", BASE + 32'h14, 32'hDEAD_BEEF, 1'b0, 1'b0, 10'd0, 32'h0);

        // Reset with two requests in flight
        i_resp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_req_valid = 1'b1;
            i_req_addr  = BASE + 32'(4 * k);
            #1;
            chk($sformatf("rs_acc%0d", k), o_req_ready, 1);
            tick();
        end
        i_req_valid = 1'b0;
        i_rst       = 1'b1;
        #1;
        chk("rs_ready_low", o_req_ready, 0);
        tick();
        #1;
        chk("rs_valid", o_resp_valid, 0);
        chk("rs_instr", o_resp_instr, 0);
        chk("rs_addr", o_resp_addr, 0);
        chk("rs_fault", o_resp_fault, 0);
        chk("rs_ready_hold", o_req_ready, 0);
        tick();
        i_rst        = 1'b0;
        i_resp_ready = 1'b1;
        #1;
        chk("rs_ready_rel", o_req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk($sformatf("rs_none%0d", k), o_resp_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
